// File: rtl/fixdiv8_seq.sv
// Sequential restoring divider for Q0.WIDTH fractions: res = floor((op1 << WIDTH) / op2), one bit per clock.
// Optional macro FIXDIV8_ROUND_EN adds a guard iteration and round-half-up on the result.
module fixdiv8_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

`ifdef FIXDIV8_ROUND_EN
  localparam int ITER_N = WIDTH + 1;
`else
  localparam int ITER_N = WIDTH;
`endif
  localparam int QW    = ITER_N;
  localparam int CNT_W = $clog2(ITER_N + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH:0]   rem_r, rem_s;
  logic [WIDTH-1:0] div_r, div_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [QW-1:0]    quot_r, quot_s;
  logic [WIDTH-1:0] res_r, res_s;
  logic             ovf_r, ovf_s;
  logic             busy_r, done_r;

  logic [WIDTH:0]   rem_sh_s;
  logic             ge_s;
  logic [QW-1:0]    quot_sh_s;
  logic [WIDTH-1:0] fin_res_s;
  logic             fin_ovf_s;

  // The remainder stays below the divisor, so shifting the WIDTH+1 register never loses a set bit.
  assign rem_sh_s  = rem_r << 1'b1;
  assign ge_s      = (rem_sh_s >= {1'b0, div_r});
  assign quot_sh_s = {quot_r[QW-2:0], ge_s};

`ifdef FIXDIV8_ROUND_EN
  logic [WIDTH:0] half_s;
  // (q + guard) >> 1 rewritten as (q >> 1) + guard to keep every bit of the sum used.
  assign half_s    = {1'b0, quot_sh_s[QW-1:1]} + {{WIDTH{1'b0}}, quot_sh_s[0]};
  assign fin_res_s = half_s[WIDTH] ? {WIDTH{1'b1}} : half_s[WIDTH-1:0];
  assign fin_ovf_s = half_s[WIDTH];
`else
  assign fin_res_s = quot_sh_s;
  assign fin_ovf_s = 1'b0;
`endif

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_s = state_r;
    rem_s   = rem_r;
    div_s   = div_r;
    cnt_s   = cnt_r;
    quot_s  = quot_r;
    res_s   = res_r;
    ovf_s   = ovf_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (op2 > op1) begin
            state_s = ST_RUN;
            rem_s   = {1'b0, op1};
            div_s   = op2;
            cnt_s   = {CNT_W{1'b0}};
            quot_s  = {QW{1'b0}};
          end else begin
            state_s = ST_DONE;
            res_s   = {WIDTH{1'b1}};
            ovf_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ge_s) begin
          rem_s = rem_sh_s - {1'b0, div_r};
        end else begin
          rem_s = rem_sh_s;
        end
        quot_s = quot_sh_s;
        cnt_s  = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_W'(ITER_N - 1)) begin
          state_s = ST_DONE;
          res_s   = fin_res_s;
          ovf_s   = fin_ovf_s;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      rem_r   <= {(WIDTH+1){1'b0}};
      div_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      quot_r  <= {QW{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      div_r   <= div_s;
      cnt_r   <= cnt_s;
      quot_r  <= quot_s;
      res_r   <= res_s;
      ovf_r   <= ovf_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign res  = res_r;
  assign ovf  = ovf_r;

endmodule
